// File: rtl/irq_ctrl_if.sv
// CPU-side register bus of the interrupt controller: decoded chip select, write strobe,
// register select, write data and registered read data.
interface irq_ctrl_if;
    logic       cs;
    logic       we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cs, output we, output addr, output din, input dout);
    modport slave  (input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source enable, level/rising-edge latching, fixed-priority vector.
// Latency: src->PEND 1 clk, PEND->irq 1 clk, read data 1 clk after address; bus never stalls.
module irq_ctrl #(
    parameter int         NSRC       = 8,
    parameter logic [7:0] RESET_MASK = 8'h00
) (
    input  logic            clk,
    input  logic            reset,
    irq_ctrl_if.slave       bus,
    input  logic [NSRC-1:0] src,
    output logic            irq
);

    localparam logic [7:0] VALID    = 8'hFF >> (8 - NSRC);
    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_VEC  = 2'd3;

    logic [7:0] src_w;
    logic [7:0] src_q;
    logic [7:0] lat_q;
    logic [7:0] mask_q;
    logic [7:0] edge_q;
    logic [7:0] pend;
    logic [7:0] act;
    logic [7:0] vec;
    logic [2:0] vec_id;
    logic [7:0] set_v;
    logic [7:0] clr_v;
    logic [7:0] lat_d;
    logic [7:0] rd_dat;
    logic       wr_en;
    logic       rd_en;

    assign wr_en = bus.cs & bus.we;
    assign rd_en = bus.cs & ~bus.we;

    always_comb begin
        src_w            = '0;
        src_w[NSRC-1:0]  = src;
    end

    // Edge-mode bits come from the latch, level-mode bits mirror the sampled request.
    assign pend = (edge_q & lat_q) | (~edge_q & src_q);
    assign act  = pend & mask_q;

    always_comb begin
        vec_id = '0;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) vec_id = 3'(i);
        end
        vec = {|act, 4'b0000, vec_id};
    end

    always_comb begin
        clr_v = '0;
        if (wr_en) begin
            case (bus.addr)
                REG_PEND: clr_v = bus.din;
                REG_VEC:  clr_v[bus.din[2:0]] = 1'b1;
                default:  clr_v = '0;
            endcase
        end
    end

    // Set beats clear so an edge arriving during an ack is not lost; level bits keep the latch empty.
    assign set_v = src_w & ~src_q;
    assign lat_d = ((lat_q & ~clr_v) | set_v) & edge_q & VALID;

    always_comb begin
        rd_dat = '0;
        case (bus.addr)
            REG_PEND: rd_dat = pend;
            REG_MASK: rd_dat = mask_q;
            REG_EDGE: rd_dat = edge_q;
            REG_VEC:  rd_dat = vec;
            default:  rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q    <= '0;
            lat_q    <= '0;
            mask_q   <= RESET_MASK & VALID;
            edge_q   <= '0;
            irq      <= 1'b0;
            bus.dout <= '0;
        end else begin
            src_q <= src_w & VALID;
            lat_q <= lat_d;
            irq   <= |act;
            if (rd_en) bus.dout <= rd_dat;
            if (wr_en && bus.addr == REG_MASK) mask_q <= bus.din & VALID;
            if (wr_en && bus.addr == REG_EDGE) edge_q <= bus.din & VALID;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register table, directed corner sequences, then random traffic vs a per-source model.
module tb_irq_ctrl;

    localparam int         NSRC = 8;
    localparam logic [7:0] RM   = 8'h05;

    logic       clk;
    logic       reset;
    logic [7:0] src;
    logic       irq;
    int         errors;
    int         checks;

    irq_ctrl_if bus();

    irq_ctrl #(.NSRC(NSRC), .RESET_MASK(RM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .src   (src),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] waddr;
        logic [7:0] wdat;
        logic [1:0] raddr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    // Model state, one bit per source.
    bit [7:0] m_lat;
    bit [7:0] m_en;
    bit [7:0] m_edge;
    bit [7:0] m_hist;
    bit       m_irq;
    bit [7:0] m_dout;

    task automatic chk(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.din = d;
        tick();
        bus.cs = 1'b0; bus.we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
        tick();
        bus.cs = 1'b0;
        d = bus.dout;
    endtask

    function automatic bit m_pend(input int i);
        return m_edge[i] ? m_lat[i] : m_hist[i];
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] a);
        logic [7:0] r;
        bit         found;
        r = 8'h00;
        found = 0;
        for (int i = 0; i < NSRC; i++) begin
            case (a)
                2'd0: r[i] = m_pend(i);
                2'd1: r[i] = m_en[i];
                2'd2: r[i] = m_edge[i];
                default: begin
                    if (!found && m_pend(i) && m_en[i]) begin
                        found = 1;
                        r = {1'b1, 4'b0000, 3'(i)};
                    end
                end
            endcase
        end
        return r;
    endfunction

    task automatic m_reset();
        logic [7:0] rm;
        rm = RM;
        m_lat = '0; m_edge = '0; m_hist = '0; m_irq = 0; m_dout = '0;
        m_en = '0;
        for (int i = 0; i < NSRC; i++) m_en[i] = rm[i];
    endtask

    task automatic m_step(input logic [7:0] s, input logic c, input logic w,
                          input logic [1:0] a, input logic [7:0] d);
        bit any;
        bit rising;
        bit cleared;
        any = 0;
        for (int i = 0; i < NSRC; i++) if (m_pend(i) && m_en[i]) any = 1;
        if (c && !w) m_dout = m_read(a);
        m_irq = any;
        for (int i = 0; i < NSRC; i++) begin
            rising  = s[i] && !m_hist[i];
            cleared = c && w && ((a == 2'd0 && d[i]) || (a == 2'd3 && int'(d[2:0]) == i));
            if (!m_edge[i])  m_lat[i] = 0;
            else if (rising) m_lat[i] = 1;
            else if (cleared) m_lat[i] = 0;
        end
        if (c && w && a == 2'd1) for (int i = 0; i < NSRC; i++) m_en[i] = d[i];
        if (c && w && a == 2'd2) for (int i = 0; i < NSRC; i++) m_edge[i] = d[i];
        for (int i = 0; i < NSRC; i++) m_hist[i] = s[i];
    endtask

    initial begin
        logic [7:0] rv;
        logic [7:0] r_src;
        logic       r_cs;
        logic       r_we;
        logic [1:0] r_addr;
        logic [7:0] r_din;

        errors = 0;
        checks = 0;
        tbl[0] = '{2'd1, 8'hFF, 2'd1, 8'hFF};
        tbl[1] = '{2'd1, 8'h3C, 2'd1, 8'h3C};
        tbl[2] = '{2'd2, 8'hA5, 2'd2, 8'hA5};
        tbl[3] = '{2'd2, 8'hFF, 2'd2, 8'hFF};
        tbl[4] = '{2'd0, 8'hFF, 2'd0, 8'h00};
        tbl[5] = '{2'd3, 8'h07, 2'd3, 8'h00};
        tbl[6] = '{2'd1, 8'h00, 2'd1, 8'h00};
        tbl[7] = '{2'd2, 8'h00, 2'd0, 8'h00};

        reset = 1'b1; src = '0;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.din = '0;
        tick(); tick();
        chk("reset_irq", {7'b0, irq}, 8'h00);
        chk("reset_dout", bus.dout, 8'h00);
        reset = 1'b0;
        rd(2'd1, rv); chk("reset_mask", rv, 8'h05);
        rd(2'd0, rv); chk("reset_pend", rv, 8'h00);
        rd(2'd3, rv); chk("reset_vec", rv, 8'h00);
        rd(2'd2, rv); chk("reset_edge", rv, 8'h00);

        for (int k = 0; k < 8; k++) begin
            wr(tbl[k].waddr, tbl[k].wdat);
            rd(tbl[k].raddr, rv);
            chk($sformatf("table_%0d", k), rv, tbl[k].exp);
        end

        // Single edge pulse through to ack.
        wr(2'd2, 8'hFF); wr(2'd1, 8'h04);
        src = 8'h04; tick(); src = 8'h00;
        chk("edge_irq_n1", {7'b0, irq}, 8'h00);
        tick();
        chk("edge_irq_n2", {7'b0, irq}, 8'h01);
        rd(2'd0, rv); chk("edge_pend", rv, 8'h04);
        rd(2'd3, rv); chk("edge_vec", rv, 8'h82);
        wr(2'd3, 8'h02);
        chk("ack_irq_n1", {7'b0, irq}, 8'h01);
        tick();
        chk("ack_irq_n2", {7'b0, irq}, 8'h00);
        rd(2'd0, rv); chk("ack_pend", rv, 8'h00);

        // Priority between two latched sources.
        wr(2'd1, 8'hFF);
        src = 8'h22; tick(); src = 8'h00;
        rd(2'd3, rv); chk("prio_vec1", rv, 8'h81);
        wr(2'd3, 8'h01);
        rd(2'd3, rv); chk("prio_vec5", rv, 8'h85);
        wr(2'd3, 8'h05);
        rd(2'd3, rv); chk("prio_vec0", rv, 8'h00);
        chk("prio_irq", {7'b0, irq}, 8'h00);

        // Level source ignores W1C.
        wr(2'd2, 8'h00); wr(2'd1, 8'h01);
        src = 8'h01; tick(); tick();
        chk("lvl_irq_on", {7'b0, irq}, 8'h01);
        wr(2'd0, 8'h01); tick();
        chk("lvl_irq_w1c", {7'b0, irq}, 8'h01);
        rd(2'd0, rv); chk("lvl_pend", rv, 8'h01);
        src = 8'h00; tick();
        chk("lvl_drop_n1", {7'b0, irq}, 8'h01);
        tick();
        chk("lvl_drop_n2", {7'b0, irq}, 8'h00);
        rd(2'd0, rv); chk("lvl_pend_off", rv, 8'h00);

        // Edge and clear in the same cycle.
        wr(2'd2, 8'hFF); wr(2'd1, 8'h00);
        src = 8'h08; bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 2'd0; bus.din = 8'h08;
        tick();
        bus.cs = 1'b0; bus.we = 1'b0; src = 8'h00;
        rd(2'd0, rv); chk("setwins_pend", rv, 8'h08);
        wr(2'd0, 8'h08);
        rd(2'd0, rv); chk("w1c_pend", rv, 8'h00);

        // Masked edge stays pending, unmask raises irq, async reset drops everything.
        src = 8'h40; tick(); src = 8'h00; tick();
        chk("masked_irq", {7'b0, irq}, 8'h00);
        rd(2'd0, rv); chk("masked_pend", rv, 8'h40);
        wr(2'd1, 8'h40);
        chk("unmask_irq_n0", {7'b0, irq}, 8'h00);
        tick();
        chk("unmask_irq_n1", {7'b0, irq}, 8'h01);
        src = 8'h40;
        #2 reset = 1'b1;
        #1;
        chk("areset_irq", {7'b0, irq}, 8'h00);
        chk("areset_dout", bus.dout, 8'h00);
        src = 8'h00;
        tick(); tick();
        reset = 1'b0;
        rd(2'd0, rv); chk("areset_pend", rv, 8'h00);
        rd(2'd1, rv); chk("areset_mask", rv, 8'h05);

        // Random traffic against the model.
        reset = 1'b1; tick(); reset = 1'b0;
        m_reset();
        r_src = 8'h00;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) r_src = 8'($urandom);
            r_cs   = ($urandom_range(0, 9) < 6);
            r_we   = $urandom_range(0, 1) == 1;
            r_addr = 2'($urandom_range(0, 3));
            r_din  = 8'($urandom);
            src = r_src; bus.cs = r_cs; bus.we = r_we; bus.addr = r_addr; bus.din = r_din;
            tick();
            m_step(r_src, r_cs, r_we, r_addr, r_din);
            chk($sformatf("rand_irq_%0d", n), {7'b0, irq}, {7'b0, m_irq});
            chk($sformatf("rand_dout_%0d", n), bus.dout, m_dout);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
